reverse_bits_stream: RTL and testbench
======================================

Name: reverse_bits_stream

Overview:
- Parametrised, registered successor of the 8-bit combinational bit reverser.
- Accepts WIDTH-bit words on a valid/ready stream and applies one of four per-word reorder modes.
- Presents each result from a single output register with backpressure, and keeps a count of completed words.
- Sits between stream producers and consumers in datapath examples (CRC, FFT index, endian conversion).

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8 and at least 8.
- CNT_WIDTH, 16, width of the completed-word counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  forward word is present
- in_ready  output  1  block can accept a word this cycle
- forward  input  WIDTH  input word
- mode  input  2  reorder mode, sampled with the word
- out_valid  output  1  reversed holds a valid result
- out_ready  input  1  consumer accepts the result this cycle
- reversed  output  WIDTH  reordered word
- out_mode  output  2  mode that produced the current result
- word_count  output  CNT_WIDTH  completed output transfers, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset: clk and rst as named; reset is synchronous and active-high. On the cycle rst is sampled high:
  - out_valid=0, reversed=0, out_mode=0, word_count=0.
  - in_ready reads 1 as soon as out_valid is 0.
  - Any in-flight result is discarded.
- Modes, indices relative to bit 0 of forward:
  - 00, full reverse: reversed[i]=forward[WIDTH-1-i].
  - 01, bit reverse within each byte: reversed[8k+j]=forward[8k+7-j].
  - 10, byte swap: byte k of reversed = byte (WIDTH/8-1-k) of forward.
  - 11, pass-through: reversed=forward.
- Identity: mode 00 equals mode 01 followed by mode 10. Verification checks this.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is combinational from out_ready, so the stage is a one-deep pipeline that accepts back-to-back words at full rate.
- Latency is 1 cycle: a word accepted at edge N appears on reversed with out_valid=1 after edge N.
- Output register update at each edge:
  - If input transfer: load reordered word and mode; out_valid=1.
  - Else if output transfer: out_valid=0; reversed and out_mode hold their last value.
  - Else: hold all values.
- Simultaneous input and output transfer: new result loads and out_valid stays 1; no bubble, no loss.
- Stability under backpressure: while out_valid=1 and out_ready=0, reversed and out_mode stay stable.
- in_valid is ignored when in_ready=0. The producer must hold the word; the block never captures it.
- word_count increments by 1 on each output transfer and wraps from 2^CNT_WIDTH-1 to 0.
- If rst and handshakes coincide, rst wins: counter and output valid are cleared, and the transfer is not counted.
- mode is only meaningful when in_valid=1 and is not registered otherwise.
- Width rule: no padding or truncation. All modes are permutations of exactly WIDTH bits.

Test Plan:
- Reset: WIDTH=32, drive rst=1 for 2 cycles with in_valid=1 -> out_valid=0, word_count=0, in_ready=1 after release.
- Modes: WIDTH=32, out_ready=1, forward=32'h12345678 with mode 00/01/10/11 -> reversed = 32'h1E6A2C48 / 32'h482C6A1E / 32'h78563412 / 32'h12345678, each 1 cycle after acceptance, matching out_mode.
- Backpressure: accept 32'h000000FF mode 00, hold out_ready=0 for 5 cycles while offering 32'hAAAAAAAA:
  - During the stall: in_ready=0 and reversed stays 32'hFF000000.
  - After out_ready=1: the next result is 32'h55555555 (mode 00).
- Streaming: 100 consecutive words with in_valid=1 and out_ready=1 -> one result per cycle, no bubbles, word_count=100.
- Counter wrap: CNT_WIDTH=4, 17 transfers -> word_count sequence reaches 15, then 0, ends at 1.
- Reset mid-operation: out_valid=1 and out_ready=0, assert rst for one cycle -> out_valid=0 and word_count=0. The pending word never transfers, and the next accepted word is output normally.
- WIDTH=8 regression, mode 00: forward=8'b10110000 -> reversed=8'b00001101, matching the original 8-bit reverser. Mode 10 equals pass-through for WIDTH=8.

Source files
------------

// File: rtl/reverse_bits_stream.sv
// Stream stage that reorders WIDTH-bit words in one of four ways.
// It holds each result in one output register with backpressure, and counts completed output transfers.
module reverse_bits_stream #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     forward,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     reversed,
    output logic [1:0]           out_mode,
    output logic [CNT_WIDTH-1:0] word_count
);

    localparam int unsigned NBYTES = WIDTH / 8;

    typedef enum logic [1:0] {
        MODE_FULL        = 2'b00,
        MODE_BIT_IN_BYTE = 2'b01,
        MODE_BYTE_SWAP   = 2'b10,
        MODE_PASS        = 2'b11
    } mode_e;

    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [1:0]           mode_q, mode_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0]     full_rev_c, bit_rev_c, byte_swap_c, reorder_c;
    logic                 in_xfer_c, out_xfer_c;

    // A free slot exists when the register is empty or is draining this cycle.
    assign in_ready   = !valid_q || out_ready;
    assign in_xfer_c  = in_valid && in_ready;
    assign out_xfer_c = valid_q && out_ready;

    // All three permutations are pure wiring; mode selects one of them.
    always_comb begin
        full_rev_c  = '0;
        bit_rev_c   = '0;
        byte_swap_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            full_rev_c[i] = forward[int'(WIDTH) - 1 - i];
        end
        for (int k = 0; k < int'(NBYTES); k++) begin
            for (int j = 0; j < 8; j++) begin
                bit_rev_c[8*k + j] = forward[8*k + 7 - j];
            end
            byte_swap_c[8*k +: 8] = forward[8*(int'(NBYTES) - 1 - k) +: 8];
        end
        case (mode_e'(mode))
            MODE_FULL:        reorder_c = full_rev_c;
            MODE_BIT_IN_BYTE: reorder_c = bit_rev_c;
            MODE_BYTE_SWAP:   reorder_c = byte_swap_c;
            default:          reorder_c = forward;
        endcase
    end

    // A load takes priority over a drain, so a simultaneous transfer leaves no bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        if (in_xfer_c) begin
            valid_d = 1'b1;
            data_d  = reorder_c;
            mode_d  = mode;
        end else if (out_xfer_c) begin
            valid_d = 1'b0;
        end
        if (out_xfer_c) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign reversed   = data_q;
    assign out_mode   = mode_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_reverse_bits_stream.sv
// Directed bench for reverse_bits_stream: a default 32-bit instance, a 4-bit-counter instance and an 8-bit instance.
module tb_reverse_bits_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Main instance: WIDTH=32, CNT_WIDTH=16
    logic        rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] forward = '0, reversed;
    logic [1:0]  mode = '0, out_mode;
    logic [15:0] word_count;

    reverse_bits_stream #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .forward(forward), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .reversed(reversed), .out_mode(out_mode),
        .word_count(word_count)
    );

    // Counter-wrap instance: WIDTH=32, CNT_WIDTH=4
    logic        rst4 = 1'b1, in_valid4 = 1'b0, out_ready4 = 1'b0;
    logic        in_ready4, out_valid4;
    logic [31:0] forward4 = '0, reversed4;
    logic [1:0]  mode4 = '0, out_mode4;
    logic [3:0]  word_count4;

    reverse_bits_stream #(.WIDTH(32), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
        .forward(forward4), .mode(mode4), .out_valid(out_valid4),
        .out_ready(out_ready4), .reversed(reversed4), .out_mode(out_mode4),
        .word_count(word_count4)
    );

    // Narrow instance: WIDTH=8
    logic        rst8 = 1'b1, in_valid8 = 1'b0, out_ready8 = 1'b0;
    logic        in_ready8, out_valid8;
    logic [7:0]  forward8 = '0, reversed8;
    logic [1:0]  mode8 = '0, out_mode8;
    logic [15:0] word_count8;

    reverse_bits_stream #(.WIDTH(8), .CNT_WIDTH(16)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
        .forward(forward8), .mode(mode8), .out_valid(out_valid8),
        .out_ready(out_ready8), .reversed(reversed8), .out_mode(out_mode8),
        .word_count(word_count8)
    );

    // Reference reorder built from streaming operators rather than index loops
    function automatic logic [31:0] model(input logic [31:0] x, input logic [1:0] m);
        logic [31:0] fr, bs, br;
        fr = {<<{x}};
        bs = {<<8{x}};
        br = {<<8{fr}};
        case (m)
            2'b00:   return fr;
            2'b01:   return br;
            2'b10:   return bs;
            default: return x;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_main();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; forward = 32'hDEADBEEF; mode = 2'b01; out_ready = 1'b0;
        rst4 = 1'b1; rst8 = 1'b1;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
        n_checks++; if (reversed !== 32'h0) begin n_fail++; $display("FAIL reset_reversed: got %h want 00000000", reversed); end
        n_checks++; if (out_mode !== 2'b00) begin n_fail++; $display("FAIL reset_out_mode: got %b want 00", out_mode); end
        rst = 1'b0; in_valid = 1'b0; rst4 = 1'b0; rst8 = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_modes();
        logic [31:0] exp_word [4];
        exp_word[0] = 32'h1E6A2C48;
        exp_word[1] = 32'h482C6A1E;
        exp_word[2] = 32'h78563412;
        exp_word[3] = 32'h12345678;
        reset_main();
        for (int m = 0; m < 4; m++) begin
            in_valid = 1'b1; forward = 32'h12345678; mode = 2'(m); out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mode%0d_valid: got %b want 1", m, out_valid); end
            n_checks++; if (reversed !== exp_word[m]) begin n_fail++; $display("FAIL mode%0d_data: got %h want %h", m, reversed, exp_word[m]); end
            n_checks++; if (out_mode !== 2'(m)) begin n_fail++; $display("FAIL mode%0d_out_mode: got %b want %b", m, out_mode, 2'(m)); end
            tick();
        end
        // bit-in-byte result fed back through byte swap must equal the full reverse
        in_valid = 1'b1; forward = 32'h482C6A1E; mode = 2'b10;
        tick();
        in_valid = 1'b0;
        n_checks++; if (reversed !== 32'h1E6A2C48) begin n_fail++; $display("FAIL identity: got %h want 1e6a2c48", reversed); end
        tick();
        n_checks++; if (word_count !== 16'd5) begin n_fail++; $display("FAIL modes_count: got %0d want 5", word_count); end
    endtask

    task automatic test_backpressure();
        reset_main();
        in_valid = 1'b1; forward = 32'h000000FF; mode = 2'b00; out_ready = 1'b0;
        tick();
        forward = 32'hAAAAAAAA;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall%0d_in_ready: got %b want 0", c, in_ready); end
            n_checks++; if (reversed !== 32'hFF000000) begin n_fail++; $display("FAIL stall%0d_data: got %h want ff000000", c, reversed); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall%0d_valid: got %b want 1", c, out_valid); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (reversed !== 32'h55555555) begin n_fail++; $display("FAIL release_data: got %h want 55555555", reversed); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL release_valid: got %b want 1", out_valid); end
        n_checks++; if (word_count !== 16'd1) begin n_fail++; $display("FAIL release_count: got %0d want 1", word_count); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", out_valid); end
        n_checks++; if (reversed !== 32'h55555555) begin n_fail++; $display("FAIL drain_hold: got %h want 55555555", reversed); end
        n_checks++; if (word_count !== 16'd2) begin n_fail++; $display("FAIL drain_count: got %0d want 2", word_count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        reset_main();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            w = 32'(i) * 32'h9E3779B9 + 32'h13579BDF;
            forward = w; mode = 2'(i % 4);
            tick();
            n_checks++; if (out_valid !== 1'b1 || reversed !== model(w, 2'(i % 4))) begin
                n_fail++; $display("FAIL stream%0d: got v=%b %h want v=1 %h", i, out_valid, reversed, model(w, 2'(i % 4)));
            end
            n_checks++; if (word_count !== 16'(i)) begin n_fail++; $display("FAIL stream%0d_count: got %0d want %0d", i, word_count, i); end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (word_count !== 16'd100) begin n_fail++; $display("FAIL stream_total: got %0d want 100", word_count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_counter_wrap();
        bit saw15 = 1'b0, saw0 = 1'b0;
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b1; forward4 = 32'hCAFEF00D; mode4 = 2'b11;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (word_count4 == 4'd15) saw15 = 1'b1;
            if (saw15 && word_count4 == 4'd0) saw0 = 1'b1;
            n_checks++; if (word_count4 !== 4'((k - 1) % 16)) begin n_fail++; $display("FAIL wrap%0d: got %0d want %0d", k, word_count4, (k - 1) % 16); end
        end
        in_valid4 = 1'b0;
        tick();
        n_checks++; if (word_count4 !== 4'd1) begin n_fail++; $display("FAIL wrap_final: got %0d want 1", word_count4); end
        n_checks++; if (!(saw15 && saw0)) begin n_fail++; $display("FAIL wrap_sequence: saw15=%b saw0=%b want 1 1", saw15, saw0); end
    endtask

    task automatic test_reset_mid();
        reset_main();
        in_valid = 1'b1; forward = 32'h0F0F0F0F; mode = 2'b00; out_ready = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b want 1", out_valid); end
        // handshake coincides with reset; reset must win and the transfer must not count
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", word_count); end
        in_valid = 1'b1; forward = 32'h12345678; mode = 2'b11;
        tick();
        in_valid = 1'b0;
        n_checks++; if (reversed !== 32'h12345678 || out_mode !== 2'b11) begin
            n_fail++; $display("FAIL mid_next: got %h/%b want 12345678/11", reversed, out_mode);
        end
        tick();
        n_checks++; if (word_count !== 16'd1) begin n_fail++; $display("FAIL mid_next_count: got %0d want 1", word_count); end
    endtask

    task automatic test_width8();
        logic [7:0] exp8 [4];
        exp8[0] = 8'b00001101;
        exp8[1] = 8'b00001101;
        exp8[2] = 8'b10110000;
        exp8[3] = 8'b10110000;
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0; out_ready8 = 1'b1;
        for (int m = 0; m < 4; m++) begin
            in_valid8 = 1'b1; forward8 = 8'b10110000; mode8 = 2'(m);
            tick();
            n_checks++; if (reversed8 !== exp8[m] || out_valid8 !== 1'b1) begin
                n_fail++; $display("FAIL w8_mode%0d: got v=%b %b want v=1 %b", m, out_valid8, reversed8, exp8[m]);
            end
        end
        in_valid8 = 1'b0;
        tick();
        n_checks++; if (word_count8 !== 16'd4) begin n_fail++; $display("FAIL w8_count: got %0d want 4", word_count8); end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_back_to_back();
        test_counter_wrap();
        test_reset_mid();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
